// File: rtl/data_mem_if.sv
// Request/response bundle between the MEM stage and the data memory responder.
// The master drives requests; the slave returns one response per accepted request.
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_size;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory with fixed response latency and
// RISC-V byte/half/word load-store semantics.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic      clk,
    input  logic      rst,
    data_mem_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        live;
    logic        hs, go_resp;

    logic        q_we;
    logic [31:0] q_addr, q_wdata;
    logic [2:0]  q_size;

    logic        a_we;
    logic [31:0] a_addr, a_wdata;
    logic [2:0]  a_size;
    logic [AW-1:0] a_idx;
    logic        a_err;
    logic [3:0]  a_be;
    logic [31:0] a_sh, a_wsh, a_rdata;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;
    logic        err_q;

    // live keeps ready low until the first edge after reset release
    assign bus.req_ready  = live && (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = (state == RESP) ? rdata_q : 32'h0;
    assign bus.resp_err   = (state == RESP) && err_q;

    assign hs = bus.req_valid && bus.req_ready;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        go_resp  = 1'b0;
        unique case (state)
            IDLE: begin
                if (hs) begin
                    if (LATENCY == 1) begin
                        state_nx = RESP;
                        go_resp  = 1'b1;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nx = RESP;
                    go_resp  = 1'b1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            live  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            live  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_we    <= 1'b0;
            q_addr  <= 32'h0;
            q_wdata <= 32'h0;
            q_size  <= 3'b0;
        end else if (hs) begin
            q_we    <= bus.req_we;
            q_addr  <= bus.req_addr;
            q_wdata <= bus.req_wdata;
            q_size  <= bus.req_size;
        end
    end

    // With LATENCY=1 the access completes on the handshake edge itself
    assign a_we    = (state == IDLE) ? bus.req_we    : q_we;
    assign a_addr  = (state == IDLE) ? bus.req_addr  : q_addr;
    assign a_wdata = (state == IDLE) ? bus.req_wdata : q_wdata;
    assign a_size  = (state == IDLE) ? bus.req_size  : q_size;
    assign a_idx   = a_addr[AW+1:2];
    assign a_sh    = mem[a_idx] >> {a_addr[1:0], 3'b000};
    assign a_wsh   = a_wdata << {a_addr[1:0], 3'b000};

    always_comb begin
        a_err   = 1'b0;
        a_be    = 4'b0000;
        a_rdata = 32'h0;
        unique case (a_size)
            3'b000: begin
                a_be    = 4'b0001 << a_addr[1:0];
                a_rdata = {{24{a_sh[7]}}, a_sh[7:0]};
            end
            3'b001: begin
                a_err   = a_addr[0];
                a_be    = a_addr[1] ? 4'b1100 : 4'b0011;
                a_rdata = {{16{a_sh[15]}}, a_sh[15:0]};
            end
            3'b010: begin
                a_err   = |a_addr[1:0];
                a_be    = 4'b1111;
                a_rdata = a_sh;
            end
            3'b100: begin
                a_err   = a_we;
                a_rdata = {24'h0, a_sh[7:0]};
            end
            3'b101: begin
                a_err   = a_we | a_addr[0];
                a_rdata = {16'h0, a_sh[15:0]};
            end
            default: a_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (go_resp) begin
            rdata_q <= (!a_we && !a_err) ? a_rdata : 32'h0;
            err_q   <= a_err;
        end
    end

    always_ff @(posedge clk) begin
        if (go_resp && a_we && !a_err) begin
            for (int i = 0; i < 4; i++) begin
                if (a_be[i]) mem[a_idx][8*i +: 8] <= a_wsh[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a byte-array model,
// using one LATENCY=2 instance and one small LATENCY=1 instance.
module tb_data_mem_responder;
    localparam int D0 = 1024;
    localparam int D1 = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_mem_if b0();
    data_mem_if b1();

    logic        t_valid [2];
    logic        t_we    [2];
    logic [31:0] t_addr  [2];
    logic [31:0] t_wdata [2];
    logic [2:0]  t_size  [2];

    assign b0.req_valid = t_valid[0];
    assign b0.req_we    = t_we[0];
    assign b0.req_addr  = t_addr[0];
    assign b0.req_wdata = t_wdata[0];
    assign b0.req_size  = t_size[0];
    assign b1.req_valid = t_valid[1];
    assign b1.req_we    = t_we[1];
    assign b1.req_addr  = t_addr[1];
    assign b1.req_wdata = t_wdata[1];
    assign b1.req_size  = t_size[1];

    data_mem_responder #(.DEPTH_WORDS(D0), .LATENCY(2)) u_dut0 (
        .clk(clk), .rst(rst), .bus(b0)
    );
    data_mem_responder #(.DEPTH_WORDS(D1), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(b1)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] mm0 [4*D0];
    logic [7:0] mm1 [4*D1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int s);
        return (s != 0) ? b1.req_ready : b0.req_ready;
    endfunction
    function automatic logic rv(input int s);
        return (s != 0) ? b1.resp_valid : b0.resp_valid;
    endfunction
    function automatic logic [31:0] rdo(input int s);
        return (s != 0) ? b1.resp_rdata : b0.resp_rdata;
    endfunction
    function automatic logic ero(input int s);
        return (s != 0) ? b1.resp_err : b0.resp_err;
    endfunction

    function automatic logic [7:0] rdb(input int s, input logic [31:0] a);
        if (s != 0) return mm1[a % (4*D1)];
        return mm0[a % (4*D0)];
    endfunction

    function automatic void wrb(input int s, input logic [31:0] a, input logic [7:0] v);
        if (s != 0) mm1[a % (4*D1)] = v;
        else        mm0[a % (4*D0)] = v;
    endfunction

    // Reference: decide legality, then act on n consecutive bytes
    function automatic void model(input int s, input logic we, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [2:0] sz,
                                  output logic [31:0] rd, output logic err);
        int n;
        bit sgn;
        longint v;
        n = 0; sgn = 0; rd = 32'h0;
        case (sz)
            3'd0: begin n = 1; sgn = 1; end
            3'd1: begin n = 2; sgn = 1; end
            3'd2: n = 4;
            3'd4: n = 1;
            3'd5: n = 2;
            default: n = 0;
        endcase
        if (n == 0) err = 1'b1;
        else err = ((a % n) != 0) || (we && sz[2]);
        if (!err) begin
            if (we) begin
                for (int i = 0; i < n; i++) wrb(s, a + i, 8'(wd >> (8*i)));
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v += longint'(rdb(s, a + i)) << (8*i);
                if (sgn && v >= (longint'(1) << (8*n - 1))) v -= longint'(1) << (8*n);
                rd = v[31:0];
            end
        end
    endfunction

    task automatic acc(input int s, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] sz,
                       output logic [31:0] rd, output logic er);
        logic [31:0] erd;
        logic eer;
        int k;
        int lat;
        lat = (s != 0) ? 1 : 2;
        model(s, we, a, wd, sz, erd, eer);
        t_we[s] = we; t_addr[s] = a; t_wdata[s] = wd; t_size[s] = sz;
        t_valid[s] = 1'b1;
        k = 0;
        while (!rdy(s) && k < 20) begin
            @(posedge clk); #1; k++;
        end
        if (!rdy(s)) begin
            chk("ready_timeout", 32'(rdy(s)), 32'd1);
            t_valid[s] = 1'b0;
            rd = 32'h0; er = 1'b0;
            return;
        end
        @(posedge clk); #1;
        t_valid[s] = 1'b0;
        k = 1;
        while (!rv(s) && k < 20) begin
            @(posedge clk); #1; k++;
        end
        chk("latency", 32'(k), 32'(lat));
        chk("rdata", rdo(s), erd);
        chk("err", 32'(ero(s)), 32'(eer));
        rd = rdo(s); er = ero(s);
        @(posedge clk); #1;
        chk("resp_drop", 32'(rv(s)), 32'd0);
        chk("ready_back", 32'(rdy(s)), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic er;
        logic [31:0] a;
        bit exp_rdy;
        for (int i = 0; i < 2; i++) begin
            t_valid[i] = 0; t_we[i] = 0; t_addr[i] = 0;
            t_wdata[i] = 0; t_size[i] = 0;
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(b0.req_ready), 0);
        chk("rst_valid", 32'(b0.resp_valid), 0);
        chk("rst_busy", 32'(b0.busy), 0);
        chk("rst_rdata", b0.resp_rdata, 0);
        chk("rst_err", 32'(b0.resp_err), 0);
        chk("rst_ready1", 32'(b1.req_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ready_pre_edge", 32'(b0.req_ready), 0);
        @(posedge clk); #1;
        chk("ready_first_edge", 32'(b0.req_ready), 1);

        for (int w = 0; w < 16; w++) acc(0, 1, 32'(4*w), $urandom, 3'd2, rd, er);
        for (int w = 0; w < D1; w++) acc(1, 1, 32'(4*w), $urandom, 3'd2, rd, er);

        acc(0, 1, 32'h10, 32'hDEADBEEF, 3'd2, rd, er);
        acc(0, 0, 32'h10, 32'h0, 3'd2, rd, er);
        chk("lw_dead", rd, 32'hDEADBEEF);
        chk("lw_dead_err", 32'(er), 0);

        acc(0, 1, 32'h10, 32'h0, 3'd2, rd, er);
        acc(0, 1, 32'h11, 32'h80, 3'd0, rd, er);
        acc(0, 0, 32'h11, 32'h0, 3'd0, rd, er);
        chk("lb_neg", rd, 32'hFFFFFF80);
        acc(0, 0, 32'h11, 32'h0, 3'd4, rd, er);
        chk("lbu", rd, 32'h00000080);
        acc(0, 0, 32'h10, 32'h0, 3'd2, rd, er);
        chk("lw_after_sb", rd, 32'h00008000);

        acc(0, 0, 32'h13, 32'h0, 3'd1, rd, er);
        chk("lh_mis_err", 32'(er), 1);
        chk("lh_mis_rdata", rd, 0);
        acc(0, 0, 32'h12, 32'h0, 3'd2, rd, er);
        chk("lw_mis_err", 32'(er), 1);
        chk("lw_mis_rdata", rd, 0);
        acc(0, 1, 32'h10, 32'hFF, 3'd4, rd, er);
        chk("sbu_err", 32'(er), 1);
        acc(0, 0, 32'h10, 32'h0, 3'd2, rd, er);
        chk("lw_unchanged", rd, 32'h00008000);

        t_we[0] = 0; t_addr[0] = 32'h10; t_size[0] = 3'd2; t_valid[0] = 1;
        for (int c = 0; c < 9; c++) begin
            exp_rdy = (c % 3 == 0);
            chk("stream_ready", 32'(b0.req_ready), 32'(exp_rdy));
            chk("stream_busy", 32'(b0.busy), 32'(!exp_rdy));
            chk("stream_valid", 32'(b0.resp_valid), 32'(c % 3 == 2));
            @(posedge clk); #1;
        end
        t_valid[0] = 0;

        t_we[0] = 1; t_addr[0] = 32'h20; t_wdata[0] = 32'h12345678;
        t_size[0] = 3'd2; t_valid[0] = 1;
        @(posedge clk); #1;
        t_valid[0] = 0;
        chk("wait_busy", 32'(b0.busy), 1);
        rst = 1'b0;
        #2;
        chk("mid_rst_busy", 32'(b0.busy), 0);
        chk("mid_rst_ready", 32'(b0.req_ready), 0);
        chk("mid_rst_valid", 32'(b0.resp_valid), 0);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("no_resp_after_rst", 32'(b0.resp_valid), 0);
        end
        acc(0, 0, 32'h20, 32'h0, 3'd2, rd, er);

        acc(1, 1, 32'(4*D1 + 16), 32'hCAFEF00D, 3'd2, rd, er);
        acc(1, 0, 32'h10, 32'h0, 3'd2, rd, er);
        chk("alias_lw", rd, 32'hCAFEF00D);

        repeat (120) begin
            a = 32'($urandom_range(0, 3) * 4 * D0) + 32'($urandom_range(0, 63));
            acc(0, 1'($urandom), a, $urandom, 3'($urandom), rd, er);
        end
        repeat (60) begin
            acc(1, 1'($urandom), $urandom, $urandom, 3'($urandom), rd, er);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, memory size in 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response (legal values 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  processor MEM stage presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port req_size  input  3  func3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 SHALL have port resp_valid  output  1  one-cycle response strobe.
REQ-012 SHALL have port resp_rdata  output  32  load data, extended per req_size.
REQ-013 SHALL have port resp_err  output  1  access rejected (misaligned or illegal size).
REQ-014 SHALL have port busy  output  1  stall request to pipeline; high when state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL assert req_ready only in IDLE; handshake = req_valid && req_ready on a rising edge.
REQ-017 SHALL, on handshake, capture we/addr/wdata/size and go to WAIT with countdown = LATENCY-1, or go directly to RESP when LATENCY = 1.
REQ-018 SHALL decrement countdown each cycle in WAIT and move to RESP on the edge where it reaches 0.
REQ-019 SHALL assert resp_valid for exactly the RESP cycle, i.e. LATENCY cycles after the handshake edge, then return to IDLE.
REQ-020 SHALL ignore req_valid outside IDLE; no request queuing.
REQ-021 SHALL index memory with addr[log2(DEPTH_WORDS)+1:2]; upper address bits ignored (wrap-around).
REQ-022 SHALL, for loads, return B/H sign-extended, BU/HU zero-extended, W unchanged, lane selected by addr[1:0].
REQ-023 SHALL, for stores, write only the addressed byte lanes (B: 1, H: 2, W: 4), with memory updated on the edge that enters RESP.
REQ-024 SHALL flag resp_err = 1 when H/HU addr[0] != 0, W addr[1:0] != 0, size in {011, 110, 111}, or a store with size in {100, 101}; in that case memory is unmodified and resp_rdata = 0.
REQ-025 SHALL drive resp_rdata = 0 for stores and whenever resp_valid = 0.
REQ-026 SHALL, on a load to a word stored in the same RESP cycle, never occur (single outstanding access); a load issued after a store response SHALL see the new data.

Reset
REQ-027 SHALL, while rst = 0, force state IDLE, req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, busy = 0, countdown = 0.
REQ-028 SHALL assert req_ready = 1 on the first rising edge after rst deasserts.
REQ-029 SHALL, on reset asserted mid-transaction (WAIT), discard the pending access, leave memory unchanged, and produce no response.
REQ-030 SHALL not clear memory contents on reset.

Verification
REQ-031 SHALL cover SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> resp_valid 2 cycles after each handshake, rdata 0xDEADBEEF, err 0.
REQ-032 SHALL cover SB 0x11 data 0x80 over 0x00000000, then LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0x00008000.
REQ-033 SHALL cover LH 0x13 and LW 0x12 -> resp_err 1, rdata 0; subsequent LW 0x10 shows memory unchanged.
REQ-034 SHALL cover req_valid held high continuously -> busy high and req_ready low in WAIT/RESP, one accept per LATENCY+1 cycles.
REQ-035 SHALL cover rst pulsed low during WAIT of SW 0x20 data 0x12345678 -> no resp_valid; LW 0x20 afterwards returns its prior value.
REQ-036 SHALL cover LATENCY = 1 and address 4*DEPTH_WORDS + 0x10 -> response next cycle, aliasing word 0x10.
